// File: rtl/orb_frame_reader.sv
// Reads the just-completed ping-pong bank and serialises each word MSB first, with no gaps.
// First bit goes out on the first bitTick after a 3-clk prime. A SW edge aborts and restarts at once.
module orb_frame_reader #(
  parameter int FRAME_WORDS = 2048,
  parameter int WORD_BITS   = 12,
  parameter int ADDR_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SW,
  input  logic                 bitTick,
  input  logic [WORD_BITS-1:0] rdData,
  output logic                 RE,
  output logic [ADDR_W-1:0]    RdAddr,
  output logic                 rdBank,
  output logic                 serOut,
  output logic                 wordStrobe,
  output logic                 frameStart,
  output logic                 busy
);

  localparam int BC_W = $clog2(WORD_BITS + 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [BC_W-1:0]   BC_FULL   = BC_W'(WORD_BITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_ARM   = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;

  logic [1:0]           r_state;
  logic                 r_sw_meta;
  logic                 r_sw_s;
  logic                 r_sw_old;
  logic [ADDR_W-1:0]    r_wc;
  logic [BC_W-1:0]      r_bc;
  logic [WORD_BITS-1:0] r_sh;
  logic [WORD_BITS-1:0] r_hold;
  logic                 r_re_d1;
  logic                 r_re_d2;

  logic                 w_edge;
  logic [ADDR_W-1:0]    w_wc_nxt;

  assign w_edge   = r_sw_s != r_sw_old;
  assign w_wc_nxt = r_wc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sw_meta  <= 1'b0;
      r_sw_s     <= 1'b0;
      r_sw_old   <= 1'b0;
      r_wc       <= '0;
      r_bc       <= '0;
      r_sh       <= '0;
      r_hold     <= '0;
      r_re_d1    <= 1'b0;
      r_re_d2    <= 1'b0;
      RE         <= 1'b0;
      RdAddr     <= '0;
      rdBank     <= 1'b0;
      serOut     <= 1'b0;
      wordStrobe <= 1'b0;
      frameStart <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_sw_meta  <= SW;
      r_sw_s     <= r_sw_meta;
      r_sw_old   <= r_sw_s;
      RE         <= 1'b0;
      wordStrobe <= 1'b0;
      frameStart <= 1'b0;
      // r_re_d2 marks the clk on which rdData belongs to the read issued 2 clk earlier
      r_re_d1    <= RE;
      r_re_d2    <= r_re_d1;
      if (r_re_d2) r_hold <= rdData;

      if (w_edge) begin
        // Flushing the read pipe keeps an aborted prefetch from landing in the new frame
        rdBank  <= r_sw_old;
        r_wc    <= '0;
        r_bc    <= '0;
        RdAddr  <= '0;
        RE      <= 1'b1;
        serOut  <= 1'b0;
        r_re_d1 <= 1'b0;
        r_re_d2 <= 1'b0;
        r_state <= S_PRIME;
      end else begin
        case (r_state)
          S_PRIME: begin
            if (r_re_d2) begin
              r_sh    <= rdData;
              r_state <= S_ARM;
            end
          end
          S_ARM: begin
            if (bitTick) begin
              serOut     <= r_sh[WORD_BITS-1];
              r_sh       <= {r_sh[WORD_BITS-2:0], 1'b0};
              r_bc       <= BC_W'(1);
              wordStrobe <= 1'b1;
              frameStart <= (r_wc == '0);
              busy       <= 1'b1;
              if (r_wc < LAST_WORD) begin
                RE     <= 1'b1;
                RdAddr <= w_wc_nxt;
              end
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (bitTick) begin
              if (r_bc != BC_FULL) begin
                serOut <= r_sh[WORD_BITS-1];
                r_sh   <= {r_sh[WORD_BITS-2:0], 1'b0};
                r_bc   <= r_bc + BC_W'(1);
              end else if (r_wc < LAST_WORD) begin
                serOut     <= r_hold[WORD_BITS-1];
                r_sh       <= {r_hold[WORD_BITS-2:0], 1'b0};
                r_wc       <= w_wc_nxt;
                r_bc       <= BC_W'(1);
                wordStrobe <= 1'b1;
                if (w_wc_nxt < LAST_WORD) begin
                  RE     <= 1'b1;
                  RdAddr <= w_wc_nxt + ADDR_W'(1);
                end
              end else begin
                serOut  <= 1'b0;
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: serOut <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orb_frame_reader.sv
// Randomised bench for orb_frame_reader: bank RAM model, stream-level reference model, literal pins.
`timescale 1ns/1ps
module tb_orb_frame_reader;
  localparam int FW = 4;
  localparam int WB = 12;
  localparam int AW = 11;
  localparam int NB = FW * WB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          SW = 1'b0;
  logic          bitTick = 1'b0;
  logic [WB-1:0] rdData = '0;
  logic          RE;
  logic [AW-1:0] RdAddr;
  logic          rdBank, serOut, wordStrobe, frameStart, busy;

  always #5 clk = ~clk;

  orb_frame_reader #(.FRAME_WORDS(FW), .WORD_BITS(WB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .SW(SW), .bitTick(bitTick), .rdData(rdData),
    .RE(RE), .RdAddr(RdAddr), .rdBank(rdBank), .serOut(serOut),
    .wordStrobe(wordStrobe), .frameStart(frameStart), .busy(busy)
  );

  // Bank RAM: 2-clk read latency, output holds until the next read returns
  logic [WB-1:0] mem [2][FW];
  logic [WB-1:0] st1 = '0;
  always @(posedge clk) begin
    if (RE && RdAddr < AW'(FW)) st1 <= mem[rdBank][RdAddr[$clog2(FW)-1:0]];
    rdData <= st1;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick generator: gap drawn from [gmin,gmax], or a single forced tick
  int gmin = 4, gmax = 4, tgap = 4, tcnt = 0;
  bit tick_en = 0, force_tick = 0;
  initial forever begin
    @(negedge clk);
    bitTick = 1'b0;
    if (force_tick) begin
      bitTick = 1'b1;
      tcnt = 0;
    end else if (tick_en) begin
      tcnt++;
      if (tcnt >= tgap) begin
        bitTick = 1'b1;
        tcnt = 0;
        tgap = $urandom_range(gmax, gmin);
      end
    end
  end

  // Reference model: frame as a flat bit index into a snapshot of the bank
  logic          m_s1 = 0, m_s2 = 0, m_old = 0;
  bit            m_act = 0;
  int            m_idx = 0, m_cyc = 0;
  logic [WB-1:0] m_frame [FW];
  logic          exp_ser = 0, exp_ws = 0, exp_fs = 0, exp_busy = 0, exp_re = 0, exp_bank = 0;
  logic [AW-1:0] exp_addr = '0;
  bit            cap_on = 0, cap_now = 0;
  logic [NB-1:0] cap = '0;
  int            ws_cnt = 0, fs_cnt = 0;

  always @(posedge clk) begin
    logic edge_v;
    int w;
    cap_now = 0;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_old = 0; m_act = 0; m_idx = 0;
      exp_ser = 0; exp_ws = 0; exp_fs = 0; exp_busy = 0; exp_re = 0;
      exp_addr = '0; exp_bank = 0;
    end else begin
      edge_v = (m_s2 != m_old);
      exp_re = 0; exp_ws = 0; exp_fs = 0;
      if (edge_v) begin
        exp_bank = m_old; exp_ser = 0; exp_re = 1; exp_addr = '0;
        m_act = 1; m_idx = 0; m_cyc = 0;
        for (int i = 0; i < FW; i++) m_frame[i] = mem[m_old][i];
      end else if (m_act) begin
        m_cyc++;
        if (bitTick && m_cyc >= 4) begin
          if (m_idx < NB) begin
            w = m_idx / WB;
            exp_ser = m_frame[w][WB-1-(m_idx%WB)];
            cap_now = 1;
            if (m_idx % WB == 0) begin
              exp_ws = 1; exp_fs = (w == 0); exp_busy = 1;
              if (w < FW-1) begin
                exp_re = 1; exp_addr = AW'(w + 1);
              end
            end
            m_idx++;
          end else begin
            exp_ser = 0; exp_busy = 0; m_act = 0;
          end
        end
      end
      m_old = m_s2; m_s2 = m_s1; m_s1 = SW;
    end
    #1;
    chk("serOut", 64'(serOut), 64'(exp_ser));
    chk("wordStrobe", 64'(wordStrobe), 64'(exp_ws));
    chk("frameStart", 64'(frameStart), 64'(exp_fs));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("RE", 64'(RE), 64'(exp_re));
    chk("RdAddr", 64'(RdAddr), 64'(exp_addr));
    chk("rdBank", 64'(rdBank), 64'(exp_bank));
    if (cap_on && cap_now) cap = {cap[NB-2:0], serOut};
    if (cap_on && wordStrobe) ws_cnt++;
    if (cap_on && frameStart) fs_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string name);
    int c = 0;
    while (busy !== lvl && c < maxc) begin
      cyc(1);
      c++;
    end
    chk(name, 64'(busy), 64'(lvl));
  endtask

  task automatic wait_idx(input int target, input int maxc, input string name);
    int c = 0;
    while (!(m_act && m_idx >= target) && c < maxc) begin
      cyc(1);
      c++;
    end
    chk(name, 64'(c < maxc), 64'd1);
  endtask

  initial begin
    int c;
    int re_cnt, busy_cnt;
    mem[0][0] = 12'hA5A; mem[0][1] = 12'h5A5; mem[0][2] = 12'hFFF; mem[0][3] = 12'h001;
    for (int i = 0; i < FW; i++) mem[1][i] = WB'($urandom);

    // Reset state
    cyc(3);
    chk("rst_RE", 64'(RE), 64'd0);
    chk("rst_RdAddr", 64'(RdAddr), 64'd0);
    chk("rst_serOut", 64'(serOut), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdBank", 64'(rdBank), 64'd0);
    rst = 1'b1;
    cyc(5);

    // Pinned frame at minimum tick spacing
    tick_en = 1; cap_on = 1;
    SW = 1'b1;
    wait_busy(1'b1, 100, "f1_busy_rise");
    wait_busy(1'b0, 1000, "f1_busy_fall");
    chk("f1_bits", 64'(cap), 64'(48'b101001011010_010110100101_111111111111_000000000001));
    chk("f1_wordStrobes", 64'(ws_cnt), 64'd4);
    chk("f1_frameStarts", 64'(fs_cnt), 64'd1);
    chk("f1_rdBank", 64'(rdBank), 64'd0);
    chk("f1_serOut_idle", 64'(serOut), 64'd0);
    cap_on = 0;

    // Abort after word 2 bit 5
    gmin = 4; gmax = 6;
    SW = 1'b0;
    cyc(4);
    wait_idx(30, 2000, "abort_reach");
    chk("abort_bank_before", 64'(rdBank), 64'd1);
    SW = 1'b1;
    c = 0;
    do begin cyc(1); c++; end while (!RE && c < 6);
    chk("abort_RE", 64'(RE), 64'd1);
    chk("abort_RdAddr", 64'(RdAddr), 64'd0);
    chk("abort_rdBank", 64'(rdBank), 64'd0);
    chk("abort_serOut", 64'(serOut), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    c = 0;
    while (!frameStart && c < 300) begin cyc(1); c++; end
    chk("abort_frameStart", 64'(frameStart), 64'd1);
    wait_busy(1'b0, 2000, "abort_done");

    // SW edge coincident with a tick while shifting
    SW = ~SW;
    cyc(4);
    wait_idx(8, 2000, "coinc_reach");
    tick_en = 0;
    cyc(6);
    SW = ~SW;
    cyc(2);
    force_tick = 1;
    cyc(1);
    force_tick = 0;
    chk("coinc_serOut", 64'(serOut), 64'd0);
    chk("coinc_RE", 64'(RE), 64'd1);
    chk("coinc_wordStrobe", 64'(wordStrobe), 64'd0);
    tick_en = 1;
    wait_busy(1'b0, 2000, "coinc_done");

    // Random toggles and tick spacings
    for (int k = 0; k < 30; k++) begin
      gmin = 4 + $urandom_range(2);
      gmax = gmin + $urandom_range(4);
      SW = ~SW;
      cyc($urandom_range(500, 30));
    end

    // Asynchronous reset mid-word
    SW = ~SW;
    cyc(4);
    wait_idx(17, 2000, "rst_reach");
    rst = 1'b0; SW = 1'b0;
    #1;
    chk("arst_RE", 64'(RE), 64'd0);
    chk("arst_RdAddr", 64'(RdAddr), 64'd0);
    chk("arst_serOut", 64'(serOut), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wordStrobe", 64'(wordStrobe), 64'd0);
    cyc(3);
    rst = 1'b1;
    re_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (RE) re_cnt++;
      if (busy) busy_cnt++;
    end
    chk("post_rst_RE", 64'(re_cnt), 64'd0);
    chk("post_rst_busy", 64'(busy_cnt), 64'd0);

    // Normal frame after reset
    SW = 1'b1;
    wait_busy(1'b1, 200, "final_busy_rise");
    wait_busy(1'b0, 2000, "final_busy_fall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/orb_frame_reader.md
Name: orb_frame_reader

Overview:
- Downstream consumer of the orbital word packer's buffer RAM, ping-pong organised.
- On each bank switch (SW toggle), reads the just-completed bank word by word.
- Serialises each 12-bit orbit word MSB first at the line bit rate, with no gaps between words.
- Drives the bank-select address bit, frame/word markers and the serial line to the transmitter stage.

Parameters:
- FRAME_WORDS, 2048: words read per frame, from address 0 to FRAME_WORDS-1.
- WORD_BITS, 12: bits per orbit word; must equal the RAM data width.
- ADDR_W, 11: RAM word address width within one bank.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- SW  in  1  bank-select from the writer side, asynchronous to the data path. A toggle means the writer has switched banks.
- bitTick  in  1  one-clk bit-rate enable. Consecutive ticks are at least 4 clk apart.
- rdData  in  WORD_BITS  RAM read data, valid 2 clk after RE/RdAddr are presented.
- RE  out  1  RAM read enable, one-clk pulse.
- RdAddr  out  ADDR_W  RAM read word address.
- rdBank  out  1  bank bit for the RAM read port (bank currently being read).
- serOut  out  1  serial data, MSB first.
- wordStrobe  out  1  one-clk pulse when the first bit (MSB) of each word appears on serOut.
- frameStart  out  1  one-clk pulse coincident with wordStrobe of word 0.
- busy  out  1  high while a frame is being serialised.

Behaviour:
- Reset values: RE=0, RdAddr=0, rdBank=0, serOut=0, wordStrobe=0, frameStart=0, busy=0. Internal state=IDLE, counters 0, SW sync/history registers 0.
- SW goes through a 2-flop synchroniser; its output is swS. An edge is swS != swOld, with swOld registered every clk.
- States:
  - IDLE: serOut=0. On an edge: rdBank<=swOld (the completed bank), word counter wc<=0, RdAddr<=0, RE=1 for one clk, go to PRIME.
  - PRIME: wait 2 clk, load rdData into shift register sh, go to ARM.
  - ARM: wait for bitTick. On the tick: serOut<=sh MSB, bit counter bc<=1, wordStrobe=1, frameStart=(wc==0), busy<=1. If wc<FRAME_WORDS-1, issue RE with RdAddr=wc+1. Go to SHIFT.
  - SHIFT: on each bitTick, serOut<=next bit and bc<=bc+1.
- Prefetch: rdData is captured into holding register hold exactly 2 clk after each prefetch RE.
- Word boundary: on the bitTick after bit WORD_BITS-1 has been output (bc==WORD_BITS):
  - If wc<FRAME_WORDS-1: sh<=hold, wc<=wc+1, emit that word's MSB on this same tick, bc<=1, wordStrobe=1, and issue the next prefetch if one remains. Words are contiguous on the line.
  - If wc==FRAME_WORDS-1 (last word): serOut<=0, busy<=0, go to IDLE.
- RE is never asserted while in IDLE, and never for addresses >= FRAME_WORDS.
- RdAddr wraps only through the frame restart; it never counts past FRAME_WORDS-1.
- SW edge in any non-IDLE state: abort the frame immediately in the same clk. serOut<=0 and wordStrobe is suppressed. Then restart exactly as from IDLE (new rdBank, RdAddr=0, RE pulse, PRIME). busy stays 1 through the restart.
- Simultaneous SW edge and bitTick: the edge wins; the tick is ignored.
- A bitTick during PRIME is ignored. The first bit goes out on the first tick seen in ARM.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. After release, the block waits in IDLE for the next SW edge.
- Line latency: from the tick that outputs a word's MSB to that word's LSB is WORD_BITS-1 ticks. Inter-word gap is 0 ticks.

Test Plan:
- Bank A filled with words 0x000..0x7FF, tick every 8 clk, SW 0->1 → rdBank=0, RdAddr sequence 0..2047, serOut reproduces all words MSB first. 2048 wordStrobe pulses, 1 frameStart on word 0, busy low after 24576 ticks.
- FRAME_WORDS=4, words 0xA5A,0x5A5,0xFFF,0x001 → serOut bits exactly 101001011010 010110100101 111111111111 000000000001, no gaps, then serOut=0 and state IDLE.
- SW toggles again after word 2 bit 5 (FRAME_WORDS=4) → serOut forced 0 that clk, rdBank flips to 1, RE at RdAddr=0 within 1 clk, new frameStart on the next ARM tick.
- SW edge and bitTick in the same clk while in SHIFT → no bit advance, restart taken, bc reloads from 0.
- rst pulsed low mid-word → RE=0, RdAddr=0, serOut=0, busy=0 immediately. No activity until the next SW edge.
- Tick spacing at the minimum of 4 clk across a word boundary → hold is loaded before the boundary tick, and the correct next MSB appears on that tick.
